spix_perm: RTL

Sequencing controller for the 256-bit SPIX permutation: it holds the four 64-bit subblocks, drives two Simeck-box (SB64) instances once per step, and applies the step mixing and subblock rotation. One SB64 instance serves subblock 1 and the other serves subblock 3. The block sits between the AEAD mode controller, which loads state and starts permutations, and the SB64 nonlinear layer.

---
 rtl/spix_pkg.sv | 41 ++++
 rtl/spix_perm_if.sv | 34 +++
 rtl/sb64.sv | 62 ++++++
 rtl/spix_step_const.sv | 24 ++
 rtl/spix_perm.sv | 126 ++++++++++++
 5 files changed

// File: rtl/spix_pkg.sv
// spix_pkg: shared definitions for the SPIX permutation controller.
//   SPIX_STEPS / SPIX_SHORT_STEPS : step counts (full / reduced permutation)
//   RC0, RC1 : per-step 8-bit round-constant words for SB-A / SB-B
//   SC0, SC1 : per-step 8-bit step constants for the x0 / x2 mix
//   spix_step_k_t     : the four constants of one step, bundled
//   spix_perm_state_t : controller FSM states
package spix_pkg;

  localparam int SPIX_STEPS       = 18;
  localparam int SPIX_SHORT_STEPS = 9;

  // Upper bits of the step-constant word XORed into x0 / x2 during mixing.
  localparam logic [55:0] SPIX_SC_PAD = 56'hFF_FFFF_FFFF_FFFF;

  localparam logic [7:0] RC0 [SPIX_STEPS] = '{
    8'h07, 8'h04, 8'h06, 8'h25, 8'h17, 8'h1C, 8'h2E, 8'h30, 8'h38,
    8'h3C, 8'h39, 8'h15, 8'h0D, 8'h22, 8'h33, 8'h1F, 8'h35, 8'h29};
  localparam logic [7:0] RC1 [SPIX_STEPS] = '{
    8'h27, 8'h34, 8'h2E, 8'h19, 8'h35, 8'h0F, 8'h08, 8'h0C, 8'h0A,
    8'h29, 8'h3D, 8'h37, 8'h1B, 8'h12, 8'h1A, 8'h0E, 8'h11, 8'h3B};
  localparam logic [7:0] SC0 [SPIX_STEPS] = '{
    8'h08, 8'h29, 8'h1D, 8'h0B, 8'h1C, 8'h2E, 8'h20, 8'h07, 8'h17,
    8'h3F, 8'h26, 8'h21, 8'h0F, 8'h09, 8'h38, 8'h2D, 8'h19, 8'h2F};
  localparam logic [7:0] SC1 [SPIX_STEPS] = '{
    8'h64, 8'h50, 8'h72, 8'h5A, 8'h6D, 8'h56, 8'h4B, 8'h3E, 8'h47,
    8'h63, 8'h52, 8'h6E, 8'h43, 8'h58, 8'h5D, 8'h4A, 8'h79, 8'h2C};

  typedef struct packed {
    logic [7:0] rc0;
    logic [7:0] rc1;
    logic [7:0] sc0;
    logic [7:0] sc1;
  } spix_step_k_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT
  } spix_perm_state_t;

endpackage

// File: rtl/spix_perm_if.sv
// spix_perm_if: request/result bundle between the AEAD mode controller
// (master) and spix_perm (slave).
//   start      : one-cycle permutation request
//   state_in   : 256-bit input state, subblock i = state_in[64*i +: 64]
//   short_perm : 9-step select, present only with SPIX_PERM_SHORT_EN
//   busy       : permutation in progress
//   done       : one-cycle completion pulse
//   state_out  : permuted state, held until the next start
interface spix_perm_if;
  logic         start;
  logic [255:0] state_in;
`ifdef SPIX_PERM_SHORT_EN
  logic         short_perm;
`endif
  logic         busy;
  logic         done;
  logic [255:0] state_out;

  modport master (
    output start, state_in,
`ifdef SPIX_PERM_SHORT_EN
    output short_perm,
`endif
    input  busy, done, state_out
  );

  modport slave (
    input  start, state_in,
`ifdef SPIX_PERM_SHORT_EN
    input  short_perm,
`endif
    output busy, done, state_out
  );
endinterface

// File: rtl/sb64.sv
// sb64: Simeck-box, 8 unkeyed Simeck-64 rounds on one 64-bit subblock.
//   clk, rst : clock, asynchronous active-high reset
//   start    : latch x_in/rc this edge, then run one round per cycle
//   x_in     : {left, right} 32-bit halves
//   rc       : one constant bit per round, bit i used in round i
//   x_out    : result, stable while valid is high and until the next start
//   valid    : one-cycle pulse in the cycle after the eighth round
module sb64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] x_in,
  input  logic [7:0]  rc,
  output logic [63:0] x_out,
  output logic        valid
);

  logic [31:0] l, r;
  logic [7:0]  rc_q;
  logic [2:0]  cnt;
  logic        running;

  function automatic logic [31:0] simeck_f(input logic [31:0] x);
    return (x & {x[26:0], x[31:27]}) ^ {x[30:0], x[31]};
  endfunction

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register here is control or datapath flop state, so all of
      // it is reset; there is no memory array that would need to be exempt.
      l       <= '0;
      r       <= '0;
      rc_q    <= '0;
      cnt     <= '0;
      running <= 1'b0;
      valid   <= 1'b0;
    end else if (start) begin
      l       <= x_in[63:32];
      r       <= x_in[31:0];
      rc_q    <= rc;
      cnt     <= '0;
      running <= 1'b1;
      valid   <= 1'b0;
    end else if (running) begin
      // Round key is all ones except bit 0, which carries the constant bit.
      l     <= r ^ simeck_f(l) ^ {31'h7FFF_FFFF, rc_q[cnt]};
      r     <= l;
      cnt   <= cnt + 3'd1;
      if (cnt == 3'd7) begin
        running <= 1'b0;
        valid   <= 1'b1;
      end
    end else begin
      valid <= 1'b0;
    end
  end

  assign x_out = {l, r};

endmodule

// File: rtl/spix_step_const.sv
// spix_step_const: combinational lookup of the per-step constants.
//   step : current step index (0 .. SPIX_STEPS-1)
//   k    : {rc0, rc1, sc0, sc1} for that step; zero beyond the table
// Kept as a separate block so an LFSR generator can replace the tables.
module spix_step_const
  import spix_pkg::*;
(
  input  logic [4:0]   step,
  output spix_step_k_t k
);

  always_comb begin
    // NOTE: the output gets a full default first, so no path leaves it
    // unassigned and no latch is inferred.
    k = '0;
    if (step < 5'(SPIX_STEPS)) begin
      k.rc0 = RC0[step];
      k.rc1 = RC1[step];
      k.sc0 = SC0[step];
      k.sc1 = SC1[step];
    end
  end

endmodule

// File: rtl/spix_perm.sv
// spix_perm: sequencing controller for the 256-bit SPIX permutation.
//   clk, rst : clock, asynchronous active-high reset (also resets both SB64s)
//   bus      : spix_perm_if.slave -- start, state_in, [short_perm],
//              busy, done, state_out
// Each step: LOAD starts SB-A on x1 and SB-B on x3, WAIT holds until both
// report valid, then x0/x2 are mixed and the subblocks rotate.
// Optional feature macro: SPIX_PERM_SHORT_EN adds short_perm (9-step mode).
module spix_perm
  import spix_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  spix_perm_if.slave  bus
);

  spix_perm_state_t state;
  logic [63:0]      x0, x1, x2, x3;
  logic [4:0]       step;
  logic [4:0]       last_step;
  logic             busy_q, done_q, sb_start;
  spix_step_k_t     k;
  logic [63:0]      y1, y3;
  logic             valid_a, valid_b;
  logic [63:0]      mix0, mix2;

`ifdef SPIX_PERM_SHORT_EN
  logic             short_q;
  assign last_step = short_q ? 5'(SPIX_SHORT_STEPS - 1) : 5'(SPIX_STEPS - 1);
`else
  assign last_step = 5'(SPIX_STEPS - 1);
`endif

  spix_step_const u_const (
    .step (step),
    .k    (k)
  );

  sb64 u_sb_a (
    .clk   (clk),
    .rst   (rst),
    .start (sb_start),
    .x_in  (x1),
    .rc    (k.rc0),
    .x_out (y1),
    .valid (valid_a)
  );

  sb64 u_sb_b (
    .clk   (clk),
    .rst   (rst),
    .start (sb_start),
    .x_in  (x3),
    .rc    (k.rc1),
    .x_out (y3),
    .valid (valid_b)
  );

  assign mix0 = x0 ^ y1 ^ {SPIX_SC_PAD, k.sc0};
  assign mix2 = x2 ^ y3 ^ {SPIX_SC_PAD, k.sc1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      x0       <= '0;
      x1       <= '0;
      x2       <= '0;
      x3       <= '0;
      step     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sb_start <= 1'b0;
`ifdef SPIX_PERM_SHORT_EN
      short_q  <= 1'b0;
`endif
    end else begin
      done_q   <= 1'b0;
      sb_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          // The done cycle still belongs to the finishing permutation, so a
          // start seen alongside done is dropped; restart is the next cycle.
          if (bus.start && !done_q) begin
            x0       <= bus.state_in[63:0];
            x1       <= bus.state_in[127:64];
            x2       <= bus.state_in[191:128];
            x3       <= bus.state_in[255:192];
            step     <= '0;
            busy_q   <= 1'b1;
            sb_start <= 1'b1;
`ifdef SPIX_PERM_SHORT_EN
            short_q  <= bus.short_perm;
`endif
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A lone valid from one box is a fault; keep waiting for both.
          if (valid_a && valid_b) begin
            x0   <= y1;
            x1   <= mix2;
            x2   <= y3;
            x3   <= mix0;
            step <= step + 5'd1;
            if (step == last_step) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= ST_IDLE;
            end else begin
              sb_start <= 1'b1;
              state    <= ST_LOAD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_out = {x3, x2, x1, x0};

endmodule
